// File: rtl/noc_local_injector_if.sv
// Requester and router-side signal bundle for the Local-port injector.
// The slave view belongs to the injector; the master view belongs to the PE cluster/router side.
interface noc_local_injector_if #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0]           req_last;
   logic [2*NREQ-1:0]         req_dst;
   logic [(WIDTH-3)*NREQ-1:0] req_payload;
   logic [NREQ-1:0]           req_ready;
   logic                      inj_full;
   logic                      inj_almost_full;
   logic                      inj_write;
   logic [WIDTH-1:0]          inj_data;

   modport master (
      output req_valid, req_last, req_dst, req_payload, inj_full, inj_almost_full,
      input  req_ready, inj_write, inj_data
   );

   modport slave (
      input  req_valid, req_last, req_dst, req_payload, inj_full, inj_almost_full,
      output req_ready, inj_write, inj_data
   );
endinterface

// File: rtl/noc_local_injector.sv
// Round-robin scheduler sharing the router Local write path among NREQ requesters,
// with a per-packet grant lock and full/almost-full throttling.
module noc_local_injector #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   noc_local_injector_if.slave  bus,
   output logic [2:0]           owner,
   output logic                 locked,
   output logic [15:0]          flit_count,
   output logic [15:0]          pkt_count
);
   localparam int PW = WIDTH - 3;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       owner_q, owner_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic             inj_write_q, inj_write_d;
   logic [WIDTH-1:0] inj_data_q, inj_data_d;
   logic [15:0]      flit_count_q, flit_count_d;
   logic [15:0]      pkt_count_q, pkt_count_d;

   logic [1:0]       dst_a [NREQ];
   logic [PW-1:0]    pl_a  [NREQ];
   logic             permit_s;
   logic             found_s;
   logic [2:0]       win_s;
   logic [3:0]       pos_s;
   logic [2:0]       sel_s;
   logic             sel_valid_s;
   logic             sel_last_s;
   logic [1:0]       sel_dst_s;
   logic [PW-1:0]    sel_pl_s;
   logic             grant_s;
   logic [NREQ-1:0]  ready_s;

   function automatic logic [2:0] next_idx(input logic [2:0] idx);
      if (idx == 3'(NREQ - 1)) begin
         return 3'd0;
      end else begin
         return idx + 3'd1;
      end
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign dst_a[g] = bus.req_dst[2*g +: 2];
      assign pl_a[g]  = bus.req_payload[PW*g +: PW];
   end

   // At most one write may land after almost-full rises: the one already in flight.
   assign permit_s = ~bus.inj_full & ~(bus.inj_almost_full & inj_write_q);

   // Round-robin search: first valid requester at or after rr_ptr, modulo NREQ.
   always_comb begin
      found_s = 1'b0;
      win_s   = 3'd0;
      pos_s   = 4'd0;
      for (int k = 0; k < NREQ; k++) begin
         pos_s = {1'b0, rr_ptr_q} + 4'(k);
         if (pos_s >= 4'(NREQ)) begin
            pos_s = pos_s - 4'(NREQ);
         end else begin
            pos_s = pos_s;
         end
         for (int j = 0; j < NREQ; j++) begin
            if (!found_s && bus.req_valid[j] && (pos_s == 4'(j))) begin
               found_s = 1'b1;
               win_s   = 3'(j);
            end else begin
               found_s = found_s;
            end
         end
      end
   end

   // Grant decision and field selection for the chosen requester.
   always_comb begin
      sel_s       = (state_q == ST_LOCKED) ? owner_q : win_s;
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      sel_dst_s   = 2'b00;
      sel_pl_s    = {PW{1'b0}};
      for (int j = 0; j < NREQ; j++) begin
         if (sel_s == 3'(j)) begin
            sel_valid_s = bus.req_valid[j];
            sel_last_s  = bus.req_last[j];
            sel_dst_s   = dst_a[j];
            sel_pl_s    = pl_a[j];
         end else begin
            sel_valid_s = sel_valid_s;
         end
      end
      case (state_q)
         ST_IDLE:   grant_s = enable & permit_s & found_s;
         ST_LOCKED: grant_s = sel_valid_s & permit_s;
         default:   grant_s = 1'b0;
      endcase
      if (reset) begin
         grant_s = 1'b0;
      end else begin
         grant_s = grant_s;
      end
      for (int j = 0; j < NREQ; j++) begin
         ready_s[j] = grant_s && (sel_s == 3'(j));
      end
   end

   // Next-state for the FSM, the formatted flit and the statistics counters.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      inj_write_d  = grant_s;
      inj_data_d   = grant_s ? {sel_pl_s, sel_dst_s, 1'b1} : {WIDTH{1'b0}};
      flit_count_d = flit_count_q + (grant_s ? 16'd1 : 16'd0);
      pkt_count_d  = pkt_count_q + ((grant_s && sel_last_s) ? 16'd1 : 16'd0);
      case (state_q)
         ST_IDLE: begin
            if (grant_s && sel_last_s) begin
               rr_ptr_d = next_idx(sel_s);
            end else if (grant_s) begin
               state_d = ST_LOCKED;
               owner_d = sel_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (grant_s && sel_last_s) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_idx(owner_q);
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset abandons any packet in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 3'd0;
         rr_ptr_q     <= 3'd0;
         inj_write_q  <= 1'b0;
         inj_data_q   <= {WIDTH{1'b0}};
         flit_count_q <= 16'd0;
         pkt_count_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         inj_write_q  <= inj_write_d;
         inj_data_q   <= inj_data_d;
         flit_count_q <= flit_count_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.inj_write = inj_write_q;
   assign bus.inj_data  = inj_data_q;
   assign owner         = owner_q;
   assign locked        = (state_q == ST_LOCKED);
   assign flit_count    = flit_count_q;
   assign pkt_count     = pkt_count_q;
endmodule

// File: tb/tb_noc_local_injector.sv
// Table-driven bench for noc_local_injector with a write scoreboard and
// hand-written single-flit and counter-wrap sequences.
module tb_noc_local_injector;
   logic        clk;
   logic        reset;
   logic        enable;
   logic [2:0]  owner;
   logic        locked;
   logic [15:0] flit_count;
   logic [15:0] pkt_count;

   int          checks;
   int          errors;
   logic [15:0] flit_exp;
   logic [15:0] pkt_exp;
   logic [16:0] sb_q[$];

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] v;
      logic [3:0] last;
      logic       full;
      logic       af;
      logic [3:0] exp_ready;
      logic       exp_locked;
      logic [2:0] exp_owner;
   } vec_t;

   vec_t vecs[$];

   noc_local_injector_if #(.WIDTH(16), .NREQ(4)) bus ();

   noc_local_injector #(.WIDTH(16), .NREQ(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .bus        (bus),
      .owner      (owner),
      .locked     (locked),
      .flit_count (flit_count),
      .pkt_count  (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] v,
                               input logic [3:0] last, input logic full, input logic af,
                               input logic [3:0] r, input logic l, input logic [2:0] o);
      vec_t t;
      t.rst = rst; t.en = en; t.v = v; t.last = last; t.full = full; t.af = af;
      t.exp_ready = r; t.exp_locked = l; t.exp_owner = o;
      return t;
   endfunction

   // One clock: drive at negedge, check req_ready, then check registered outputs after the edge.
   task automatic cycle(input logic rst, input logic en, input logic [3:0] v, input logic [3:0] last,
                        input logic [7:0] dst, input logic [51:0] pl, input logic full, input logic af,
                        input logic [3:0] exp_ready, input logic exp_locked, input logic [2:0] exp_owner,
                        input string tag);
      logic        exp_wr;
      logic [15:0] exp_data;
      logic [16:0] got;
      @(negedge clk);
      reset = rst;
      enable = en;
      bus.req_valid = v;
      bus.req_last = last;
      bus.req_dst = dst;
      bus.req_payload = pl;
      bus.inj_full = full;
      bus.inj_almost_full = af;
      #1;
      chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(exp_ready));
      exp_wr = 1'b0;
      exp_data = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         if (exp_ready[i]) begin
            exp_wr = 1'b1;
            exp_data = {pl[13*i +: 13], dst[2*i +: 2], 1'b1};
         end
      end
      if (rst) begin
         flit_exp = 16'd0;
         pkt_exp = 16'd0;
      end else if (exp_wr) begin
         flit_exp = flit_exp + 16'd1;
         if ((exp_ready & last) != 4'b0000) pkt_exp = pkt_exp + 16'd1;
      end
      sb_q.push_back({exp_wr, exp_data});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         got = sb_q.pop_front();
         chk({tag, " inj_write"}, 32'(bus.inj_write), 32'(got[16]));
         chk({tag, " inj_data"}, 32'(bus.inj_data), 32'(got[15:0]));
      end
      chk({tag, " locked"}, 32'(locked), 32'(exp_locked));
      chk({tag, " owner"}, 32'(owner), 32'(exp_owner));
      chk({tag, " flit_count"}, 32'(flit_count), 32'(flit_exp));
      chk({tag, " pkt_count"}, 32'(pkt_count), 32'(pkt_exp));
   endtask

   initial begin
      logic [7:0]  dst;
      logic [51:0] pl;
      clk = 1'b0;
      reset = 1'b1;
      enable = 1'b0;
      bus.req_valid = 4'b0000;
      bus.req_last = 4'b0000;
      bus.req_dst = 8'h00;
      bus.req_payload = 52'h0;
      bus.inj_full = 1'b0;
      bus.inj_almost_full = 1'b0;
      checks = 0;
      errors = 0;
      flit_exp = 16'd0;
      pkt_exp = 16'd0;

      //                rst   en    valid    last     full  af    ready    lock  owner
      vecs.push_back(mk(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd0));
      // req2 three-flit packet, with a bubble, while req0/req1 keep requesting
      vecs.push_back(mk(1'b0, 1'b1, 4'b0111, 4'b0011, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0111, 4'b0011, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0111, 4'b0111, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1011, 4'b1011, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd2));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd2));
      // enable off in IDLE, then enable dropped mid-packet
      vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 3'd1));
      vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 3'd1));
      vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd1));
      vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1));
      vecs.push_back(mk(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd1));
      // reset mid-packet drops the lock and the round-robin pointer
      vecs.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 3'd3));
      vecs.push_back(mk(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1100, 4'b1100, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1100, 4'b1100, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0));

      for (int n = 0; n < vecs.size(); n++) begin
         for (int i = 0; i < 4; i++) begin
            dst[2*i +: 2] = 2'(n + i);
            pl[13*i +: 13] = 13'(n * 37 + i * 5 + 1);
         end
         cycle(vecs[n].rst, vecs[n].en, vecs[n].v, vecs[n].last, dst, pl, vecs[n].full, vecs[n].af,
               vecs[n].exp_ready, vecs[n].exp_locked, vecs[n].exp_owner, $sformatf("vec%0d", n));
      end

      // single-flit packet with a fixed, hand-computed flit
      cycle(1'b1, 1'b1, 4'b0000, 4'b0000, 8'h00, 52'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, "single_rst");
      cycle(1'b0, 1'b1, 4'b0001, 4'b0001, 8'b0000_0001, 52'h0AB, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, "single");
      chk("single flit value", 32'(bus.inj_data), 32'h0000_055B);
      chk("single flit_count", 32'(flit_count), 32'd1);
      chk("single pkt_count", 32'(pkt_count), 32'd1);

      // counter wrap after 65536 single-flit accepts
      cycle(1'b1, 1'b1, 4'b0000, 4'b0000, 8'h00, 52'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, "wrap_rst");
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
      bus.req_valid = 4'b0001;
      bus.req_last = 4'b0001;
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap flit_count max", 32'(flit_count), 32'h0000_FFFF);
      chk("wrap pkt_count max", 32'(pkt_count), 32'h0000_FFFF);
      @(posedge clk);
      #1;
      chk("wrap flit_count zero", 32'(flit_count), 32'd0);
      chk("wrap pkt_count zero", 32'(pkt_count), 32'd0);
      chk("wrap inj_write", 32'(bus.inj_write), 32'd1);
      @(negedge clk);
      bus.req_valid = 4'b0000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Round-robin injection scheduler for the router's Local input port. It shares the single Local write path between `NREQ` processing-element requesters and formats each request into a router flit. It keeps multi-flit packets contiguous with a per-packet grant lock, and throttles on the router FIFO's full/almost-full flags. It sits between the PE cluster and the router instance's `writeL`/`dataInL`/`fullL`/`almost_fullL` pins.

## Interface
- `WIDTH`, 16: flit width. Flit layout: bit0 = valid, [2:1] = destination port code (East 00, West 01, Local 10, PORT3 11), [WIDTH-1:3] = payload.
- `NREQ`, 4: number of requesters, 2..8.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: permits new packet grants.
- `req_valid` input NREQ: requester i has a flit pending.
- `req_last` input NREQ: the pending flit of requester i ends its packet.
- `req_dst` input 2*NREQ: destination code of requester i, bits [2i+1:2i].
- `req_payload` input (WIDTH-3)*NREQ: payload of requester i, slice i.
- `req_ready` output NREQ: combinational one-hot accept; a flit transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `inj_full` input 1: router Local FIFO full (`fullL`).
- `inj_almost_full` input 1: router Local FIFO almost full (`almost_fullL`).
- `inj_write` output 1: registered write strobe to `writeL`.
- `inj_data` output WIDTH: registered flit to `dataInL`.
- `owner` output 3: current lock owner index, valid when `locked`=1.
- `locked` output 1: FSM is in LOCKED.
- `flit_count` output 16: total flits injected, wraps at 2^16.
- `pkt_count` output 16: total packets completed (flits accepted with `req_last`=1), wraps.

## Operation
- `permit` = ~`inj_full` & ~(`inj_almost_full` & `inj_write`). This is combinational on the current inputs and the registered `inj_write`. It guarantees no write is issued into a full FIFO and at most one write lands after almost-full asserts.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If `enable` & `permit` & |`req_valid`, the winner is the first i with `req_valid[i]`=1, searching from `rr_ptr` upward modulo NREQ.
  - `req_ready[winner]`=1 and the flit is accepted.
  - If `req_last[winner]`=1: a single-flit packet; stay IDLE and set `rr_ptr` <= winner+1 mod NREQ.
  - Else: go to LOCKED with `owner` <= winner.
- LOCKED:
  - Only `owner` may be granted. `req_ready[owner]` = `req_valid[owner]` & `permit`, independent of `enable`.
  - On an accepted flit with `req_last`=1: go to IDLE and set `rr_ptr` <= `owner`+1 mod NREQ.
  - Other requesters see `req_ready`=0 for the whole packet.
- Accepted flit formatting: `inj_data` <= {payload_i, dst_i, 1'b1}, `inj_write` <= 1. On a cycle with no accept: `inj_write` <= 0, `inj_data` <= 0.
- `flit_count` increments on every accept. `pkt_count` increments on every accept with `req_last`=1. Both may increment in the same cycle.
- Destination codes are passed through unchecked; code 10 (Local) loops back to this PE's ejection port.
- `enable` falling while LOCKED does not truncate the packet; the FSM returns to IDLE after `last`, then grants nothing.

## Timing
- Reset values: `inj_write`=0, `inj_data`=0, state IDLE, `locked`=0, `owner`=0, `rr_ptr`=0, `flit_count`=0, `pkt_count`=0. `req_ready`=0 during the reset cycle.
- Latency: a flit accepted in cycle t appears on `inj_data` with `inj_write`=1 in cycle t+1.
- Throughput: 1 flit/cycle while `permit` holds.
- Almost-full throttling: if `inj_almost_full` rises with a write outstanding, there is a 1-cycle gap. Writes resume when the flags clear.
- `req_ready` depends on `req_valid`, `permit` and state only. It never depends on `req_payload`.
- Mid-packet reset: the lock is dropped and a partially sent packet is abandoned. The requester must restart the packet after reset.
- Simultaneous requests in IDLE: exactly one grant per cycle. Every persistently requesting PE is served within NREQ packet grants.

## Test plan
- Single flit: reset, then req0 valid, last=1, dst=01, payload=0x0AB. Required: `req_ready`=0001 in cycle t; in t+1, `inj_write`=1 and `inj_data`=0x0AB<<3 | 0b011 = 0x055B; `flit_count`=1, `pkt_count`=1.
- Round-robin: all 4 requesters hold valid single-flit packets with `permit` held. Required: grants in order 0,1,2,3,0; `inj_write`=1 on every cycle.
- Lock: req2 sends a 3-flit packet while req0 and req1 request. Required: 3 consecutive grants to req2 with `locked`=1 and `owner`=2; next grant goes to req3 if valid, else req0.
- Backpressure: `inj_full`=1 for 5 cycles with req1 valid. Required: `req_ready`=0 and `inj_write`=0 for those cycles. Separately, `inj_almost_full` asserted with `inj_write`=1 produces exactly one gap cycle.
- Enable and reset: drop `enable` mid-packet. Required: the packet completes, then no grants. Asserting `reset` mid-packet gives all outputs 0 and `locked`=0 on the next cycle.
- Counter wrap: preload by 65536 single-flit accepts. Required: `flit_count` returns to 0 and `pkt_count` returns to 0.
